controle_busca: RTL

CONTROLE_BUSCA -- requirements
Module: controle_busca

---
 rtl/redux_pkg.sv | 16 +
 rtl/controle_busca.sv | 94 +++++++++
 2 files changed

// File: rtl/redux_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package redux_pkg;

    localparam int unsigned LARGURA_END_PADRAO  = 8;
    localparam int unsigned LARGURA_INST_PADRAO = 8;
    localparam logic [7:0]  END_INICIAL_PADRAO  = 8'd0;
    localparam logic [7:0]  OPCODE_FIM_PADRAO   = 8'hFF;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/controle_busca.sv
// Instruction-fetch controller: walks a PC through an external memory and hands each
// instruction to a decoder over a valid/ready handshake until the end opcode or a halt.
module controle_busca
    import redux_pkg::*;
#(
    parameter int unsigned              LARGURA_END  = LARGURA_END_PADRAO,
    parameter int unsigned              LARGURA_INST = LARGURA_INST_PADRAO,
    parameter logic [LARGURA_END-1:0]   END_INICIAL  = LARGURA_END'(END_INICIAL_PADRAO),
    parameter logic [LARGURA_INST-1:0]  OPCODE_FIM   = LARGURA_INST'(OPCODE_FIM_PADRAO)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    iniciar,
    output logic [LARGURA_END-1:0]  endereco,
    input  logic [LARGURA_INST-1:0] instrucao,
    output logic [LARGURA_INST-1:0] inst_saida,
    output logic                    inst_valida,
    input  logic                    inst_pronta,
    input  logic                    desvio,
    input  logic [LARGURA_END-1:0]  destino_desvio,
    input  logic                    parar,
    output logic                    executando,
    output logic                    finalizado
);

    estado_t                 r_estado;
    estado_t                 w_estado_prox;
    logic [LARGURA_END-1:0]  r_pc;
    logic [LARGURA_END-1:0]  w_pc_prox;
    logic [LARGURA_END-1:0]  w_pc_mais1;
    logic                    w_pc_max;
    logic [LARGURA_INST-1:0] r_inst;
    logic [LARGURA_INST-1:0] w_inst_prox;

    assign w_pc_mais1 = r_pc + LARGURA_END'(1);
    assign w_pc_max   = (r_pc == {LARGURA_END{1'b1}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= OCIOSO;
            r_pc     <= END_INICIAL;
            r_inst   <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_pc     <= w_pc_prox;
            r_inst   <= w_inst_prox;
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        w_pc_prox     = r_pc;
        w_inst_prox   = r_inst;
        case (r_estado)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    w_pc_prox     = END_INICIAL;
                    w_estado_prox = BUSCA;
                end
            end
            BUSCA: begin
                // A halt here drops the fetch so nothing is ever presented.
                if (parar) begin
                    w_estado_prox = FIM;
                end else begin
                    w_inst_prox   = instrucao;
                    w_estado_prox = (instrucao == OPCODE_FIM) ? FIM : ENTREGA;
                end
            end
            ENTREGA: begin
                if (parar) begin
                    w_estado_prox = FIM;
                end else if (inst_pronta) begin
                    if (desvio) begin
                        w_pc_prox     = destino_desvio;
                        w_estado_prox = BUSCA;
                    end else begin
                        // Running off the top of memory ends the program at address 0.
                        w_pc_prox     = w_pc_mais1;
                        w_estado_prox = w_pc_max ? FIM : BUSCA;
                    end
                end
            end
            default: w_estado_prox = OCIOSO;
        endcase
    end

    assign endereco    = r_pc;
    assign inst_saida  = r_inst;
    assign inst_valida = (r_estado == ENTREGA);
    assign executando  = (r_estado == BUSCA) || (r_estado == ENTREGA);
    assign finalizado  = (r_estado == FIM);

endmodule
